pipelined_memory: RTL and testbench
===================================

PIPELINED_MEMORY -- requirements
Module: pipelined_memory

Interface
REQ-001 Parameter XLEN, default 32, data/address width in bits.
REQ-002 Parameter MEM_SIZE, default 1024, memory size in bytes.
REQ-003 Parameter LATENCY, default 1, cycles from request acceptance to resp_valid; legal range 1..15.
REQ-004 Parameter ALLOW_MISALIGNED, default 1; 0 = halfword/word not naturally aligned is a fault.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clock  input  1  rising-edge clock.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  block can accept a request.
REQ-010 req_write  input  1  1 = store, 0 = load.
REQ-011 req_addr  input  XLEN  byte address.
REQ-012 req_wdata  input  XLEN  store data, little-endian, low bytes used.
REQ-013 req_width  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-014 resp_valid  output  1  response present.
REQ-015 resp_ready  input  1  consumer accepts response.
REQ-016 resp_rdata  output  XLEN  load data, extended per req_width; 0 for stores and faults.
REQ-017 resp_fault  output  1  request faulted.

Function
REQ-018 Acceptance SHALL occur on a rising edge with req_valid && req_ready; req_ready SHALL be 1 only in state IDLE.
REQ-019 FSM states: IDLE, WAIT, RESP; IDLE->WAIT on acceptance when LATENCY>1, IDLE->RESP when LATENCY==1; WAIT->RESP when the down-counter (loaded LATENCY-2) reaches 0; RESP->IDLE on resp_ready.
REQ-020 resp_valid SHALL be 1 exactly in RESP, first asserted LATENCY cycles after the acceptance edge.
REQ-021 At most one request outstanding; minimum spacing between acceptances is LATENCY+1 cycles.
REQ-022 resp_rdata/resp_fault SHALL be registered and held stable while resp_valid && !resp_ready.
REQ-023 Store bytes SHALL be written and load bytes captured at the acceptance edge; a load after a store to the same address returns the stored data.
REQ-024 Byte order little-endian: byte addr+k holds bits [8k+7:8k].
REQ-025 Loads: 000 sign-extends bit 7, 001 sign-extends bit 15, 100/101 zero-extend, 010 full word.
REQ-026 Fault SHALL be set when: width not legal (stores: only 000/001/010); addr==0; any touched byte addr+k >= MEM_SIZE or addr+k wraps past 2^XLEN; misaligned with ALLOW_MISALIGNED==0.
REQ-027 A faulting store SHALL modify no byte; a faulting request SHALL still take LATENCY cycles and complete the handshake.
REQ-028 req_valid while not IDLE SHALL be ignored (held by requester per valid/ready rules).

Reset
REQ-029 On reset_n low: state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_fault 0, req_ready 1 after deassertion.
REQ-030 Memory contents SHALL not be reset; reset mid-operation drops the pending response; a store accepted before reset stays committed.

Structure
REQ-031 Package mem_pkg SHALL hold the width encoding enum (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU) and the FSM state enum.
REQ-032 Fault detection SHALL be a combinational sub-module mem_fault_check (addr, width, write -> fault), parametrised by XLEN, MEM_SIZE, ALLOW_MISALIGNED.

Verification
REQ-033 Store W 0xDEADBEEF @0x10, load W @0x10, LATENCY=3 -> resp_valid 3 cycles after each acceptance, rdata 0xDEADBEEF, fault 0.
REQ-034 After REQ-033, load B @0x10 -> 0xFFFFFFEF; BU @0x10 -> 0x000000EF; H @0x12 -> 0xFFFFDEAD; HU @0x12 -> 0x0000DEAD.
REQ-035 Load W @0x3FE (MEM_SIZE 1024), load @0x0, store width 100, and with ALLOW_MISALIGNED=0 load W @0x11 -> fault 1, rdata 0, memory unchanged.
REQ-036 resp_ready held 0 for 5 cycles -> resp_valid/rdata stable, req_ready 0, second req_valid not accepted until handshake.
REQ-037 reset_n low during WAIT after store 0x12345678 @0x20 -> resp_valid 0, req_ready 1 after release, load @0x20 returns 0x12345678.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: access-width encoding and FSM state types shared by pipelined_memory
package mem_pkg;
   typedef enum logic [2:0] {
      MEM_B  = 3'b000,
      MEM_H  = 3'b001,
      MEM_W  = 3'b010,
      MEM_BU = 3'b100,
      MEM_HU = 3'b101
   } mem_width_t;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;
endpackage

// File: rtl/mem_fault_check.sv
// mem_fault_check: combinational legality check of one memory request
module mem_fault_check import mem_pkg::*; #(
   parameter int XLEN             = 32,
   parameter int MEM_SIZE         = 1024,
   parameter int ALLOW_MISALIGNED = 1
) (
   input  logic [XLEN-1:0] addr,
   input  logic [2:0]      width,
   input  logic            write,
   output logic            fault
);
   localparam int NB = XLEN / 8;
   logic            legal;
   logic            misaligned;
   logic [XLEN-1:0] span;
   logic [XLEN:0]   last;
   // span is the offset of the last touched byte; one extra bit catches address wrap
   assign legal      = width inside {MEM_B, MEM_H, MEM_W} || (!write && width inside {MEM_BU, MEM_HU});
   assign span       = width[1] ? XLEN'(NB - 1) : XLEN'(width[0]);
   assign last       = {1'b0, addr} + {1'b0, span};
   assign misaligned = |(addr & span);
   assign fault      = !legal || addr == '0 || last >= (XLEN+1)'(MEM_SIZE) ||
                       (ALLOW_MISALIGNED == 0 && misaligned);
endmodule

// File: rtl/pipelined_memory.sv
// pipelined_memory: byte-addressed memory with fixed-latency valid/ready request/response
module pipelined_memory import mem_pkg::*; #(
   parameter int XLEN             = 32,
   parameter int MEM_SIZE         = 1024,
   parameter int LATENCY          = 1,
   parameter int ALLOW_MISALIGNED = 1
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [2:0]      req_width,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_fault
);
   localparam int NB = XLEN / 8;
   localparam int AW = $clog2(MEM_SIZE);
   mem_state_t      state, state_n;
   mem_width_t      w;
   logic [3:0]      cnt, cnt_n;
   logic [7:0]      mem [MEM_SIZE];
   logic            accept, fault;
   logic [XLEN-1:0] raw, load_data;
   mem_fault_check #(
      .XLEN(XLEN), .MEM_SIZE(MEM_SIZE), .ALLOW_MISALIGNED(ALLOW_MISALIGNED)
   ) u_fault (
      .addr(req_addr), .width(req_width), .write(req_write), .fault(fault)
   );
   assign w          = mem_width_t'(req_width);
   assign req_ready  = state == IDLE;
   assign resp_valid = state == RESP;
   assign accept     = req_valid && req_ready;
   always_comb begin
      raw = '0;
      for (int k = 0; k < NB; k++) raw[8*k +: 8] = mem[AW'(req_addr + XLEN'(k))];
   end
   assign load_data = w == MEM_B  ? {{(XLEN-8){raw[7]}}, raw[7:0]}
                    : w == MEM_H  ? {{(XLEN-16){raw[15]}}, raw[15:0]}
                    : w == MEM_BU ? XLEN'(raw[7:0])
                    : w == MEM_HU ? XLEN'(raw[15:0]) : raw;
   // contents survive reset; only legal stores commit, at the acceptance edge
   always_ff @(posedge clock)
      if (accept && req_write && !fault)
         for (int k = 0; k < NB; k++)
            if (k == 0 || (k == 1 && w != MEM_B) || w == MEM_W)
               mem[AW'(req_addr + XLEN'(k))] <= req_wdata[8*k +: 8];
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      if (accept) begin
         state_n = LATENCY == 1 ? RESP : WAIT;
         cnt_n   = LATENCY > 1 ? 4'(LATENCY - 2) : '0;
      end else if (state == WAIT) begin
         state_n = cnt == '0 ? RESP : WAIT;
         cnt_n   = cnt == '0 ? cnt : cnt - 4'd1;
      end else if (state == RESP && resp_ready) begin
         state_n = IDLE;
      end
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         resp_rdata <= '0;
         resp_fault <= 1'b0;
      end else if (accept) begin
         resp_rdata <= (fault || req_write) ? '0 : load_data;
         resp_fault <= fault;
      end
endmodule

// File: tb/tb_pipelined_memory.sv
// tb_pipelined_memory: directed requests checked against a byte-array reference model
module tb_pipelined_memory;
   localparam int LAT = 3;
   logic        clock = 0, reset_n = 1;
   logic        req_valid = 0, req_write = 0, resp_ready = 1;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic [2:0]  req_width = 0;
   logic        req_ready, resp_valid, resp_fault;
   logic [31:0] resp_rdata;
   int          tests = 0, fails = 0, cyc = 0;
   logic [7:0]  model_mem [1024];
   logic        outstanding = 0;
   int          acc_cyc = 0;
   logic [31:0] exp_rdata = 0;
   logic        exp_fault = 0;

   pipelined_memory #(
      .XLEN(32), .MEM_SIZE(1024), .LATENCY(LAT), .ALLOW_MISALIGNED(0)
   ) dut (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_width(req_width),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_fault(resp_fault)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference behaviour: bytes touched, legality and extension from first principles
   function automatic void model_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                     input logic [2:0] wd, output logic [31:0] rd, output logic rf);
      int n;
      longint last;
      n = (wd == 3'b000 || wd == 3'b100) ? 1 : (wd == 3'b001 || wd == 3'b101) ? 2 : 4;
      rf = !(wd == 3'b000 || wd == 3'b001 || wd == 3'b010 || (!wr && (wd == 3'b100 || wd == 3'b101)));
      last = longint'(a) + n - 1;
      rf = rf || a == 0 || last >= 1024 || (a % n) != 0;
      rd = 0;
      if (!rf) begin
         if (wr) begin
            for (int k = 0; k < n; k++) model_mem[int'(a) + k] = d[8*k +: 8];
         end else begin
            for (int k = 0; k < n; k++) rd[8*k +: 8] = model_mem[int'(a) + k];
            if (wd == 3'b000 && rd[7]) rd = rd | 32'hFFFF_FF00;
            if (wd == 3'b001 && rd[15]) rd = rd | 32'hFFFF_0000;
         end
      end
   endfunction

   always @(negedge clock) begin
      logic ev;
      if (!reset_n) begin
         outstanding = 0;
         chk("rst_resp_valid", 32'(resp_valid), 0);
         chk("rst_req_ready", 32'(req_ready), 1);
         chk("rst_rdata", resp_rdata, 0);
         chk("rst_fault", 32'(resp_fault), 0);
      end else begin
         ev = outstanding && (cyc - acc_cyc >= LAT - 1);
         chk("req_ready", 32'(req_ready), 32'(!outstanding));
         chk("resp_valid", 32'(resp_valid), 32'(ev));
         if (ev) begin
            chk("resp_rdata", resp_rdata, exp_rdata);
            chk("resp_fault", 32'(resp_fault), 32'(exp_fault));
            if (resp_ready) outstanding = 0;
         end else if (!outstanding && req_valid) begin
            model_req(req_write, req_addr, req_wdata, req_width, exp_rdata, exp_fault);
            acc_cyc = cyc + 1;
            outstanding = 1;
         end
      end
   end

   // called at posedge+1; returns at posedge+1 after the response handshake
   task automatic req_chk(input string name, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] wd, input logic [31:0] exp_rd, input logic exp_f, input int hold);
      int t;
      logic [31:0] rd;
      logic rf;
      req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; req_width = wd;
      resp_ready = hold == 0;
      t = 0;
      @(negedge clock);
      while (!req_ready && t < 20) begin @(negedge clock); t++; end
      chk({name, "_accept"}, 32'(req_ready), 1);
      @(posedge clock);
      #1 req_valid = hold > 0;
      t = 0;
      @(negedge clock);
      while (!resp_valid && t < 20) begin @(negedge clock); t++; end
      chk({name, "_resp"}, 32'(resp_valid), 1);
      rd = resp_rdata;
      rf = resp_fault;
      repeat (hold) @(posedge clock);
      #1 req_valid = 0; resp_ready = 1;
      @(posedge clock);
      #1;
      chk({name, "_rdata"}, rd, exp_rd);
      chk({name, "_fault"}, 32'(rf), 32'(exp_f));
   endtask

   initial begin
      #2 reset_n = 0;
      repeat (3) @(posedge clock);
      #1 reset_n = 1;
      #1 chk("post_rst_ready", 32'(req_ready), 1);
      chk("post_rst_valid", 32'(resp_valid), 0);
      @(posedge clock);
      #1;
      req_chk("st_w",      1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        0, 0);
      req_chk("ld_w",      0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 0, 0);
      req_chk("ld_b",      0, 32'h10,  32'h0,        3'b000, 32'hFFFFFFEF, 0, 0);
      req_chk("ld_bu",     0, 32'h10,  32'h0,        3'b100, 32'h000000EF, 0, 0);
      req_chk("ld_h",      0, 32'h12,  32'h0,        3'b001, 32'hFFFFDEAD, 0, 0);
      req_chk("ld_hu",     0, 32'h12,  32'h0,        3'b101, 32'h0000DEAD, 0, 0);
      req_chk("ld_w_end",  0, 32'h3FE, 32'h0,        3'b010, 32'h0,        1, 0);
      req_chk("ld_zero",   0, 32'h0,   32'h0,        3'b000, 32'h0,        1, 0);
      req_chk("st_bad_w",  1, 32'h10,  32'h11111111, 3'b100, 32'h0,        1, 0);
      req_chk("ld_misal",  0, 32'h11,  32'h0,        3'b010, 32'h0,        1, 0);
      req_chk("st_misal",  1, 32'h11,  32'h55555555, 3'b010, 32'h0,        1, 0);
      req_chk("ld_bad_w",  0, 32'h10,  32'h0,        3'b011, 32'h0,        1, 0);
      req_chk("ld_wrap",   0, 32'hFFFFFFFC, 32'h0,   3'b010, 32'h0,        1, 0);
      req_chk("ld_unchg",  0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 0, 0);
      req_chk("st_h_end",  1, 32'h3FE, 32'h0000ABCD, 3'b001, 32'h0,        0, 0);
      req_chk("ld_bu_end", 0, 32'h3FF, 32'h0,        3'b100, 32'h000000AB, 0, 0);
      req_chk("ld_h_end",  0, 32'h3FE, 32'h0,        3'b001, 32'hFFFFABCD, 0, 0);
      req_chk("st_b",      1, 32'h11,  32'h00000077, 3'b000, 32'h0,        0, 0);
      req_chk("ld_b_pos",  0, 32'h10,  32'h0,        3'b010, 32'hDEAD77EF, 0, 0);
      req_chk("hold",      0, 32'h12,  32'h0,        3'b101, 32'h0000DEAD, 0, 5);
      req_valid = 1; req_write = 1; req_addr = 32'h20; req_wdata = 32'h12345678; req_width = 3'b010;
      @(negedge clock);
      chk("rw_accept", 32'(req_ready), 1);
      @(posedge clock);
      #1 req_valid = 0;
      @(posedge clock);
      #1 reset_n = 0;
      #1 chk("rw_rst_valid", 32'(resp_valid), 0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1;
      @(negedge clock);
      chk("rw_ready", 32'(req_ready), 1);
      chk("rw_valid", 32'(resp_valid), 0);
      @(posedge clock);
      #1;
      req_chk("ld_after_rst", 0, 32'h20, 32'h0, 3'b010, 32'h12345678, 0, 0);
      repeat (2) @(posedge clock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
